// File: rtl/serial_pattern_tx_if.sv
// Load-side handshake bundle for serial_pattern_tx: a pattern word and repetition
// count offered with valid/ready.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_count;

  modport master (
    output load_valid,
    output load_data,
    output load_count,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_count,
    output load_ready
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured word out MSB-first, repeated
// load_count times, with GAP idle cycles between repetitions.
module serial_pattern_tx #(
  parameter int WIDTH = 5,
  parameter int GAP   = 0,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_pattern_tx_if.slave   ld,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 done
);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [WIDTH-1:0]   word_reg, word_next;
  logic [BW-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]   rep_reg, rep_next;
  logic               gap_last;
  logic               accept;

  generate
    if (GAP > 0) begin : g_gap
      localparam int GW = $clog2(GAP + 1);
      logic [GW-1:0] gap_cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          gap_cnt_reg <= '0;
        end else if (state_reg == S_GAP) begin
          gap_cnt_reg <= gap_cnt_reg + GW'(1);
        end else begin
          gap_cnt_reg <= '0;
        end
      end

      assign gap_last = (gap_cnt_reg == GW'(GAP - 1));
    end else begin : g_no_gap
      assign gap_last = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      word_reg    <= '0;
      bit_cnt_reg <= '0;
      rep_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      word_reg    <= word_next;
      bit_cnt_reg <= bit_cnt_next;
      rep_reg     <= rep_next;
    end
  end

  assign accept = ld.load_valid && ld.load_ready;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    word_next    = word_reg;
    bit_cnt_next = bit_cnt_reg;
    rep_next     = rep_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        // DONE also accepts, so a new transfer can start one cycle after the last bit
        if (accept) begin
          word_next    = ld.load_data;
          shift_next   = ld.load_data;
          bit_cnt_next = '0;
          rep_next     = ld.load_count;
          state_next   = (ld.load_count != '0) ? S_SHIFT : S_DONE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
        bit_cnt_next = bit_cnt_reg + BW'(1);
        if (bit_cnt_reg == BW'(WIDTH - 1)) begin
          bit_cnt_next = '0;
          rep_next     = rep_reg - CNT_W'(1);
          if (rep_reg == CNT_W'(1)) begin
            state_next = S_DONE;
          end else if (GAP == 0) begin
            shift_next = word_reg;
          end else begin
            state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_last) begin
          state_next = S_SHIFT;
          shift_next = word_reg;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ld.load_ready = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign dout_valid    = (state_reg == S_SHIFT);
  assign dout          = (state_reg == S_SHIFT) && shift_reg[WIDTH-1];
  assign busy          = (state_reg == S_SHIFT) || (state_reg == S_GAP);
  assign done          = (state_reg == S_DONE);
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: GAP=0 and GAP=2 instances checked cycle by cycle
// against an expected bit stream built from the word, count and gap.
module tb_serial_pattern_tx;
  localparam int W  = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(W), .CNT_W(CW)) bus0 ();
  serial_pattern_tx_if #(.WIDTH(W), .CNT_W(CW)) bus2 ();

  logic dout0, dv0, busy0, done0;
  logic dout2, dv2, busy2, done2;

  serial_pattern_tx #(.WIDTH(W), .GAP(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .ld(bus0.slave),
    .dout(dout0), .dout_valid(dv0), .busy(busy0), .done(done0)
  );

  serial_pattern_tx #(.WIDTH(W), .GAP(2), .CNT_W(CW)) dut2 (
    .clk(clk), .rst(rst), .ld(bus2.slave),
    .dout(dout2), .dout_valid(dv2), .busy(busy2), .done(done2)
  );

  int sel = 0;
  logic [4:0] obs;
  always_comb begin
    obs = {dv0, dout0, busy0, done0, bus0.load_ready};
    if (sel == 2) obs = {dv2, dout2, busy2, done2, bus2.load_ready};
  end

  int errors = 0;
  int checks = 0;
  bit exp_v[$];
  bit exp_d[$];

  // Reference stream: per repetition WIDTH bits MSB first, then g idle cycles between repetitions
  function automatic void build(input logic [W-1:0] w, input int c, input int g);
    exp_v.delete();
    exp_d.delete();
    for (int r = 0; r < c; r++) begin
      for (int b = W - 1; b >= 0; b--) begin
        exp_v.push_back(1'b1);
        exp_d.push_back(w[b]);
      end
      if (r < c - 1) begin
        for (int j = 0; j < g; j++) begin
          exp_v.push_back(1'b0);
          exp_d.push_back(1'b0);
        end
      end
    end
  endfunction

  // Expected {dout_valid, dout, busy, done, load_ready} k cycles after acceptance
  function automatic logic [4:0] exp_at(input int k);
    int n = exp_v.size();
    if (k <= n) return {exp_v[k-1], exp_d[k-1], 1'b1, 1'b0, 1'b0};
    if (k == n + 1) return 5'b00011;
    return 5'b00001;
  endfunction

  task automatic set_load(input logic v, input logic [W-1:0] w, input logic [CW-1:0] c);
    bus0.load_valid = (sel == 0) ? v : 1'b0;
    bus0.load_data  = w;
    bus0.load_count = c;
    bus2.load_valid = (sel == 2) ? v : 1'b0;
    bus2.load_data  = w;
    bus2.load_count = c;
  endtask

  task automatic offer(input logic [W-1:0] w, input logic [CW-1:0] c);
    @(negedge clk);
    set_load(1'b1, w, c);
    @(posedge clk);
  endtask

  task automatic test_reset();
    set_load(1'b0, '0, '0);
    repeat (2) @(negedge clk);
    for (int s = 0; s <= 2; s += 2) begin
      sel = s;
      #1;
      if (obs !== 5'b00001) begin
        errors++;
        $display("FAIL reset dut%0d: got dv,d,busy,done,rdy=%b want %b", s, obs, 5'b00001);
      end
      checks++;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] w, input int c, input int g);
    int n;
    build(w, c, g);
    n = exp_v.size();
    offer(w, CW'(c));
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k == 1) set_load(1'b0, '0, '0);
      if (obs !== exp_at(k)) begin
        errors++;
        $display("FAIL %s w=%b c=%0d cycle %0d: got dv,d,busy,done,rdy=%b want %b",
                 name, w, c, k, obs, exp_at(k));
      end
      checks++;
    end
  endtask

  task automatic test_single();
    sel = 0;
    run_and_check("single_c1", 5'b10110, 1, 0);
    run_and_check("single_c2", 5'b10110, 2, 0);
    repeat (4) run_and_check("single_rand", W'($urandom_range(0, 31)), $urandom_range(1, 3), 0);
  endtask

  task automatic test_gap();
    sel = 2;
    run_and_check("gap_c2", 5'b10110, 2, 2);
    repeat (3) run_and_check("gap_rand", W'($urandom_range(0, 31)), $urandom_range(1, 3), 2);
  endtask

  task automatic test_count_zero();
    for (int s = 0; s <= 2; s += 2) begin
      sel = s;
      run_and_check("count_zero", W'($urandom_range(0, 31)), 0, s);
    end
  endtask

  task automatic test_max_count();
    sel = 0;
    run_and_check("max_count", W'($urandom_range(0, 31)), (1 << CW) - 1, 0);
  endtask

  task automatic test_mid_transfer();
    int n;
    sel = 0;
    build(5'b11001, 3, 0);
    n = exp_v.size();
    offer(5'b11001, 4'd3);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k == 1) set_load(1'b0, '0, '0);
      if (k == 2) set_load(1'b1, 5'b00000, CW'($urandom_range(0, 15)));
      if (k == n) set_load(1'b0, '0, '0);
      if (obs !== exp_at(k)) begin
        errors++;
        $display("FAIL mid_transfer cycle %0d: got dv,d,busy,done,rdy=%b want %b", k, obs, exp_at(k));
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] wa, wb;
    int ca, cb, n;
    for (int s = 0; s <= 2; s += 2) begin
      sel = s;
      wa = W'($urandom_range(0, 31));
      wb = W'($urandom_range(0, 31));
      ca = $urandom_range(1, 3);
      cb = $urandom_range(1, 3);
      build(wa, ca, s);
      n = exp_v.size();
      offer(wa, CW'(ca));
      for (int k = 1; k <= n + 1; k++) begin
        @(negedge clk);
        if (k == 1) set_load(1'b0, '0, '0);
        if (obs !== exp_at(k)) begin
          errors++;
          $display("FAIL b2b_first gap=%0d cycle %0d: got dv,d,busy,done,rdy=%b want %b", s, k, obs, exp_at(k));
        end
        checks++;
      end
      set_load(1'b1, wb, CW'(cb));
      @(posedge clk);
      build(wb, cb, s);
      n = exp_v.size();
      for (int k = 1; k <= n + 2; k++) begin
        @(negedge clk);
        if (k == 1) set_load(1'b0, '0, '0);
        if (obs !== exp_at(k)) begin
          errors++;
          $display("FAIL b2b_second gap=%0d cycle %0d: got dv,d,busy,done,rdy=%b want %b", s, k, obs, exp_at(k));
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_abort();
    sel = 0;
    build(5'b10111, 2, 0);
    offer(5'b10111, 4'd2);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) set_load(1'b0, '0, '0);
      if (obs !== exp_at(k)) begin
        errors++;
        $display("FAIL abort_pre cycle %0d: got dv,d,busy,done,rdy=%b want %b", k, obs, exp_at(k));
      end
      checks++;
    end
    rst = 1'b0;
    #1;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL abort_immediate: got dv,d,busy,done,rdy=%b want %b", obs, 5'b00001);
    end
    checks++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (obs !== 5'b00001) begin
        errors++;
        $display("FAIL abort_after cycle %0d: got dv,d,busy,done,rdy=%b want %b", k, obs, 5'b00001);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_count_zero();
    test_mid_transfer();
    test_back_to_back();
    test_max_count();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
